// File: rtl/ir_pkg.sv
// Shared types and defaults for the multi-word SAP instruction register.
package ir_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } ir_state_t;

    localparam int DEF_BUS_W        = 8;
    localparam int DEF_OPCODE_W     = 4;
    localparam int DEF_MAX_OPERANDS = 2;

    function automatic int imm_width(input int bus_w, input int opcode_w);
        return bus_w - opcode_w;
    endfunction

endpackage

// File: rtl/ir_operand_bank.sv
// Operand register file: one write port, one read port that returns zero
// for indices at or beyond the current instruction's operand count.
module ir_operand_bank
    import ir_pkg::*;
#(
    parameter int BUS_W        = DEF_BUS_W,
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS,
    parameter int SEL_W        = 1,
    parameter int LEN_W        = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [SEL_W-1:0] wr_idx,
    input  logic [BUS_W-1:0] wr_data,
    input  logic [SEL_W-1:0] rd_idx,
    input  logic [LEN_W-1:0] rd_len,
    output logic [BUS_W-1:0] rd_data
);

    logic [BUS_W-1:0] mem [MAX_OPERANDS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (LEN_W'(rd_idx) < rd_len) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/multi_byte_ir.sv
// Variable-length instruction register on the shared W-bus.
// Define IR_INSN_COUNT_EN to build the 16-bit opcode-load counter.
module multi_byte_ir
    import ir_pkg::*;
#(
    parameter int BUS_W        = DEF_BUS_W,
    parameter int OPCODE_W     = DEF_OPCODE_W,
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic                                                  load_ir,
    input  logic                                                  output_to_bus,
    input  logic                                                  clear,
    input  logic [$clog2(MAX_OPERANDS+1)-1:0]                     op_len,
    input  logic [((MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1)-1:0] operand_sel,
    output logic [OPCODE_W-1:0]                                   instruction,
    output logic                                                  ir_ready,
    output logic                                                  fetching,
    output logic                                                  len_err,
    output logic [15:0]                                           insn_count,
    inout  wire  [BUS_W-1:0]                                      w_bus
);

    localparam int IMM_W = imm_width(BUS_W, OPCODE_W);
    localparam int LEN_W = $clog2(MAX_OPERANDS + 1);
    localparam int SEL_W = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;

    ir_state_t        state, state_next;
    logic [BUS_W-1:0] opcode_word;
    logic [LEN_W-1:0] len, len_in;
    logic [SEL_W-1:0] idx;
    logic             over;
    logic             opcode_load, operand_load;
    logic             drive_en;
    logic [BUS_W-1:0] drive_val, operand_rd;

    assign over   = op_len > LEN_W'(MAX_OPERANDS);
    assign len_in = over ? LEN_W'(MAX_OPERANDS) : op_len;

    // A load in READY starts the next instruction, exactly like a load in EMPTY.
    always_comb begin
        state_next   = state;
        opcode_load  = 1'b0;
        operand_load = 1'b0;
        if (clear) begin
            state_next = EMPTY;
        end else if (load_ir) begin
            unique case (state)
                FETCH: begin
                    operand_load = 1'b1;
                    if (LEN_W'(idx) == len - 1'b1) begin
                        state_next = READY;
                    end
                end
                default: begin
                    opcode_load = 1'b1;
                    state_next  = (len_in == '0) ? READY : FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= EMPTY;
            opcode_word <= '0;
            len         <= '0;
            idx         <= '0;
            len_err     <= 1'b0;
        end else begin
            state <= state_next;
            if (opcode_load) begin
                opcode_word <= w_bus;
                len         <= len_in;
                idx         <= '0;
                if (over) begin
                    len_err <= 1'b1;
                end
            end else if (operand_load) begin
                idx <= idx + 1'b1;
            end
        end
    end

    ir_operand_bank #(
        .BUS_W        (BUS_W),
        .MAX_OPERANDS (MAX_OPERANDS),
        .SEL_W        (SEL_W),
        .LEN_W        (LEN_W)
    ) u_bank (
        .clock   (clock),
        .reset   (reset),
        .we      (operand_load),
        .wr_idx  (idx),
        .wr_data (w_bus),
        .rd_idx  (operand_sel),
        .rd_len  (len),
        .rd_data (operand_rd)
    );

    assign instruction = opcode_word[BUS_W-1 -: OPCODE_W];
    assign ir_ready    = (state == READY);
    assign fetching    = (state == FETCH);

    // A simultaneous load owns the bus, so the register never drives it then.
    assign drive_en  = output_to_bus && !load_ir && (state != EMPTY);
    assign drive_val = (len == '0) ? BUS_W'(opcode_word[IMM_W-1:0]) : operand_rd;
    assign w_bus     = drive_en ? drive_val : {BUS_W{1'bz}};

`ifdef IR_INSN_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (opcode_load) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign insn_count = count_q;
`else
    assign insn_count = 16'd0;
`endif

endmodule

// File: doc/multi_byte_ir.md
Name: multi_byte_ir

Overview:
Parametrised instruction register for the SAP-class CPU.
- Captures a variable-length instruction from the shared W-bus: one opcode word, then 0..MAX_OPERANDS operand words, one per load strobe.
- Presents the opcode to the controller and drives the immediate field or a selected operand back onto the bus.
- Sits between the W-bus and the control sequencer; replaces the single-word IR.

Parameters:
BUS_W, 8, W-bus width in bits
OPCODE_W, 4, opcode field width (MSBs of the opcode word); BUS_W-OPCODE_W LSBs form the immediate field
MAX_OPERANDS, 2, maximum operand words per instruction (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous active-high reset
load_ir  in  1  capture w_bus this cycle (opcode or next operand, per state)
output_to_bus  in  1  drive selected field onto w_bus
clear  in  1  synchronous abort, return to empty
op_len  in  $clog2(MAX_OPERANDS+1)  operand count for the opcode currently on w_bus, from the external decoder; sampled only on opcode load
operand_sel  in  $clog2(MAX_OPERANDS)  operand index driven when op_len>0
instruction  out  OPCODE_W  registered opcode
ir_ready  out  1  complete instruction held
fetching  out  1  awaiting operand words
len_err  out  1  sticky: op_len exceeded MAX_OPERANDS
insn_count  out  16  opcodes loaded (optional feature)
w_bus  inout  BUS_W  shared bus, tri-stated when not driving

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clock and reset.
- Reset has priority over all inputs. On reset:
  - state=EMPTY
  - instruction=0, ir_ready=0, fetching=0, len_err=0, insn_count=0
  - opcode word and operand bank cleared to 0
- clear (no reset): state=EMPTY, ir_ready=0, fetching=0. Opcode and operands are retained. len_err and insn_count are unchanged. clear has priority over load_ir.
- States:
  - EMPTY, load_ir: capture opcode word, latch len=min(op_len,MAX_OPERANDS), idx=0. Go to READY if len==0, else FETCH.
  - FETCH, load_ir: operand[idx]<=w_bus, idx++. When idx==len-1, go to READY.
  - READY, load_ir: treated as a new opcode load, same as EMPTY (back-to-back instructions).
  - No load_ir: hold state.
- op_len>MAX_OPERANDS: clamp to MAX_OPERANDS and set len_err (sticky until reset).
- Outputs:
  - instruction updates one cycle after the opcode load, i.e. registered from the captured word.
  - ir_ready=1 only in READY. fetching=1 only in FETCH.
- Bus drive (combinational, zero latency). Enabled when output_to_bus && !load_ir && state!=EMPTY.
  - len==0: immediate field zero-extended to BUS_W.
  - len>0: operand[operand_sel].
  - operand_sel>=len drives 0.
  - Otherwise the bus is all-Z.
  - load_ir and output_to_bus together: load wins, no drive.
- reset or clear in the middle of FETCH abandons the partial instruction. The next load_ir is taken as an opcode.

Optional Feature:
Macro IR_INSN_COUNT_EN.
- Defined: insn_count increments, wrapping mod 2^16, on every opcode load (not operand loads).
- Undefined: insn_count is tied to 0 and no counter flops are built.

Decomposition:
- Package ir_pkg:
  - state enum ir_state_t {EMPTY, FETCH, READY}
  - default-width localparams
  - a function computing the immediate-field width
- Sub-module ir_operand_bank: MAX_OPERANDS x BUS_W register file with write index, write enable, sync clear, and a read port with out-of-range-to-zero.

Test Plan:
- Reset: assert reset with load_ir=1, w_bus=8'hA5 -> next cycle instruction=0, ir_ready=0, w_bus=Z.
- Single-word instruction: load 8'h3C with op_len=0 -> READY after 1 edge, instruction=4'h3; output_to_bus -> w_bus=8'h0C.
- Two-operand instruction: load 8'h52 (op_len=2), then 8'h11, then 8'h22 -> fetching=1 for 2 cycles, then ir_ready. operand_sel=1 drives 8'h22.
- Overlength: op_len=3 with MAX_OPERANDS=2 -> len_err=1, READY after 2 operand loads. len_err persists through clear and drops only on reset.
- Abort and back-to-back: clear after the first operand -> EMPTY; next load 8'h70 (op_len=0) -> instruction=4'h7. A load while in READY starts a new instruction. insn_count=2 when IR_INSN_COUNT_EN is defined, 0 otherwise.
- Contention: load_ir=1 and output_to_bus=1 in the same cycle -> block does not drive w_bus, and the bus value is captured.
